// File: rtl/clksw_pkg.sv
// Shared types and constants for the HS/LS clock switch sequencer.
package clksw_pkg;

    typedef enum logic [1:0] {
        LS_RUN = 2'd0,
        TO_HS  = 2'd1,
        HS_RUN = 2'd2,
        TO_LS  = 2'd3
    } clksw_state_e;

    localparam logic [1:0] DIV_1 = 2'b00;
    localparam logic [1:0] DIV_2 = 2'b01;
    localparam logic [1:0] DIV_4 = 2'b10;
    localparam logic [1:0] DIV_8 = 2'b11;

endpackage

// File: rtl/clksw_sequencer_if.sv
// Request/status bundle between the sequencer and the HS/LS clock switch.
interface clksw_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             hs_en;
    logic             slow_req;
    logic [1:0]       div_sel_req;
    logic             hsclk_selected;
    logic             lsclk_selected;
    logic             err_clr;
    logic             hsclk_sel;
    logic [1:0]       cpuclk_div_sel;
    logic             busy;
    logic             running_hs;
    logic             timeout_err;
    logic [CNT_W-1:0] switch_count;

    modport master (
        input  hs_en, slow_req, div_sel_req, hsclk_selected, lsclk_selected, err_clr,
        output hsclk_sel, cpuclk_div_sel, busy, running_hs, timeout_err, switch_count
    );

    modport slave (
        output hs_en, slow_req, div_sel_req, hsclk_selected, lsclk_selected, err_clr,
        input  hsclk_sel, cpuclk_div_sel, busy, running_hs, timeout_err, switch_count
    );
endinterface

// File: rtl/clksw_sequencer_sync2_ff.sv
// Two-flop synchronizer with asynchronous active-low reset and configurable reset value.
module sync2_ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_b_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/clksw_sequencer.sv
// Drives hsclk_sel / cpuclk_div_sel of the HS/LS clock switch from the lsclk domain,
// with minimum LS dwell, switch timeout and divider changes only while HS is gated off.
module clksw_sequencer
    import clksw_pkg::*;
#(
    parameter int unsigned MIN_LS_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [1:0]  DIV_RST        = DIV_1,
    parameter int unsigned CNT_W          = 8
) (
    input  logic              lsclk_in,
    input  logic              rst_b,
    clksw_sequencer_if.master bus
);
    localparam logic [7:0] MIN_DWELL  = 8'(MIN_LS_CYCLES);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    clksw_state_e     state_q, state_d;
    logic [7:0]       dwell_q, dwell_d, dwell_inc;
    logic [7:0]       timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       div_q, div_d;
    logic             hsclk_sel_q, hsclk_sel_d;
    logic             busy_q, busy_d;
    logic             run_q, run_d;
    logic             err_q, err_d;
    logic             hs_sync;
    logic             in_transit;
    logic             timeout;

    sync2_ff #(
        .RST_VAL(1'b0)
    ) u_hs_sync (
        .clk_i  (lsclk_in),
        .rst_b_i(rst_b),
        .d_i    (bus.hsclk_selected),
        .q_o    (hs_sync)
    );

    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        timer_d     = '0;
        count_d     = count_q;
        div_d       = div_q;
        err_d       = err_q;
        dwell_inc   = (dwell_q == MIN_DWELL) ? dwell_q : dwell_q + 8'd1;
        in_transit  = (state_q == TO_HS) || (state_q == TO_LS);
        timeout     = in_transit && (timer_q == TIMER_LAST);

        unique case (state_q)
            LS_RUN: begin
                dwell_d = dwell_inc;
                if (!hs_sync) begin
                    div_d = bus.div_sel_req;
                end
                // The current LS cycle counts toward the dwell, so LS_RUN lasts exactly MIN_LS_CYCLES.
                if (bus.hs_en && !bus.slow_req && (dwell_inc == MIN_DWELL) && !hs_sync) begin
                    state_d = TO_HS;
                end
            end
            TO_HS: begin
                if (hs_sync) begin
                    state_d = HS_RUN;
                    count_d = count_q + CNT_W'(1);
                end else if (bus.slow_req || !bus.hs_en) begin
                    state_d = TO_LS;
                end
            end
            HS_RUN: begin
                if (bus.slow_req || !bus.hs_en) begin
                    state_d = TO_LS;
                end
            end
            TO_LS: begin
                if (bus.lsclk_selected && !hs_sync) begin
                    state_d = LS_RUN;
                end
            end
        endcase

        // Timeout overrides whatever the state logic above decided this cycle.
        if (timeout) begin
            state_d = LS_RUN;
            count_d = count_q;
            err_d   = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end

        if ((state_d == state_q) && in_transit) begin
            timer_d = timer_q + 8'd1;
        end

        if ((state_d == LS_RUN) && (state_q != LS_RUN)) begin
            dwell_d = '0;
        end

        hsclk_sel_d = (state_d == TO_HS) || (state_d == HS_RUN);
        busy_d      = (state_d == TO_HS) || (state_d == TO_LS);
        run_d       = (state_d == HS_RUN);
    end

    always_ff @(posedge lsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= LS_RUN;
            dwell_q     <= '0;
            timer_q     <= '0;
            count_q     <= '0;
            div_q       <= DIV_RST;
            hsclk_sel_q <= 1'b0;
            busy_q      <= 1'b0;
            run_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            timer_q     <= timer_d;
            count_q     <= count_d;
            div_q       <= div_d;
            hsclk_sel_q <= hsclk_sel_d;
            busy_q      <= busy_d;
            run_q       <= run_d;
            err_q       <= err_d;
        end
    end

    assign bus.hsclk_sel      = hsclk_sel_q;
    assign bus.cpuclk_div_sel = div_q;
    assign bus.busy           = busy_q;
    assign bus.running_hs     = run_q;
    assign bus.timeout_err    = err_q;
    assign bus.switch_count   = count_q;
endmodule

// File: tb/tb_clksw_sequencer.sv
// Randomized bench for clksw_sequencer with a clock-switch model and a behavioural reference.
module tb_clksw_sequencer;
    import clksw_pkg::*;

    localparam int unsigned MIN_LS  = 4;
    localparam int unsigned TMO     = 16;
    localparam int unsigned CNT_W   = 8;
    localparam logic [1:0]  DIV_RST = DIV_1;

    logic lsclk_in = 1'b0;
    logic rst_b    = 1'b0;

    clksw_sequencer_if #(.CNT_W(CNT_W)) bus ();

    clksw_sequencer #(
        .MIN_LS_CYCLES (MIN_LS),
        .TIMEOUT_CYCLES(TMO),
        .DIV_RST       (DIV_RST),
        .CNT_W         (CNT_W)
    ) dut (
        .lsclk_in(lsclk_in),
        .rst_b   (rst_b),
        .bus     (bus)
    );

    always #5 lsclk_in = ~lsclk_in;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: sel/busy pair describes the phase (LS, heading HS, HS, heading LS).
    bit         m_sel, m_busy, m_err;
    bit   [1:0] m_sync;
    logic [1:0] m_div;
    int         m_ls_cycles, m_transit, m_count;

    task automatic model_reset();
        m_sel = 0; m_busy = 0; m_err = 0; m_sync = '0;
        m_div = DIV_RST; m_ls_cycles = 0; m_transit = 0; m_count = 0;
    endtask

    task automatic model_step();
        bit hs  = m_sync[1];
        bit tmo = 0;
        m_sync = {m_sync[0], bus.hsclk_selected};
        if (m_busy) begin
            m_transit++;
            tmo = (m_transit >= int'(TMO));
        end
        if (tmo) begin
            m_sel = 0; m_busy = 0; m_ls_cycles = 0; m_err = 1;
        end else begin
            if (bus.err_clr) m_err = 0;
            if (!m_sel && !m_busy) begin
                if (m_ls_cycles < int'(MIN_LS)) m_ls_cycles++;
                if (!hs) m_div = bus.div_sel_req;
                if (bus.hs_en && !bus.slow_req && m_ls_cycles == int'(MIN_LS) && !hs) begin
                    m_sel = 1; m_busy = 1; m_transit = 0;
                end
            end else if (m_sel && m_busy) begin
                if (hs) begin
                    m_busy = 0;
                    m_count = (m_count + 1) % (1 << CNT_W);
                end else if (bus.slow_req || !bus.hs_en) begin
                    m_sel = 0; m_transit = 0;
                end
            end else if (m_sel) begin
                if (bus.slow_req || !bus.hs_en) begin
                    m_sel = 0; m_busy = 1; m_transit = 0;
                end
            end else begin
                if (bus.lsclk_selected && !hs) begin
                    m_busy = 0; m_ls_cycles = 0;
                end
            end
        end
    endtask

    // Clock-switch model: follows hsclk_sel after a per-request delay.
    bit sw_hs;
    int sw_cnt, sw_delay, fixed_delay, never_pct, slow_div;

    function automatic int pick_delay();
        if (fixed_delay != 0) return fixed_delay;
        if ($urandom_range(0, 99) < never_pct) return 40;
        return int'($urandom_range(1, 6));
    endfunction

    task automatic sw_reset();
        sw_hs = 0; sw_cnt = 0; sw_delay = 1;
        bus.hsclk_selected = 1'b0;
        bus.lsclk_selected = 1'b1;
    endtask

    task automatic sw_step();
        if (bus.hsclk_sel != sw_hs) begin
            if (sw_cnt == 0) sw_delay = pick_delay();
            sw_cnt++;
            if (sw_cnt >= sw_delay) begin
                sw_hs = bus.hsclk_sel;
                sw_cnt = 0;
            end
        end else begin
            sw_cnt = 0;
        end
        bus.hsclk_selected = sw_hs;
        bus.lsclk_selected = !sw_hs;
    endtask

    task automatic drive(input bit rnd);
        rst_b = 1'b1;
        sw_step();
        if (rnd) begin
            if ($urandom_range(0, slow_div - 1) == 0) bus.slow_req = ~bus.slow_req;
            if ($urandom_range(0, 39) == 0) bus.hs_en = ~bus.hs_en;
            if ($urandom_range(0, 7) == 0) bus.div_sel_req = 2'($urandom_range(0, 3));
            bus.err_clr = ($urandom_range(0, 19) == 0);
        end
    endtask

    task automatic compare_model();
        check("hsclk_sel", 32'(bus.hsclk_sel), 32'(m_sel));
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("running_hs", 32'(bus.running_hs), 32'(m_sel && !m_busy));
        check("cpuclk_div_sel", 32'(bus.cpuclk_div_sel), 32'(m_div));
        check("timeout_err", 32'(bus.timeout_err), 32'(m_err));
        check("switch_count", 32'(bus.switch_count), 32'(m_count));
    endtask

    task automatic do_cycle(input bit rnd);
        @(negedge lsclk_in);
        drive(rnd);
        @(posedge lsclk_in);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sel"}, 32'(bus.hsclk_sel), 32'(0));
        check({tag, "_div"}, 32'(bus.cpuclk_div_sel), 32'(DIV_RST));
        check({tag, "_busy"}, 32'(bus.busy), 32'(0));
        check({tag, "_run"}, 32'(bus.running_hs), 32'(0));
        check({tag, "_err"}, 32'(bus.timeout_err), 32'(0));
        check({tag, "_cnt"}, 32'(bus.switch_count), 32'(0));
    endtask

    // Asserted between edges; held through one active edge, released by the next do_cycle.
    task automatic async_reset(input string tag);
        #2 rst_b = 1'b0;
        #1 check_reset({tag, "_now"});
        model_reset();
        sw_reset();
        @(posedge lsclk_in);
        #1 check_reset({tag, "_hold"});
    endtask

    initial begin
        int n;
        int first_rise;
        int run_cyc;

        bus.hs_en = 1'b1; bus.slow_req = 1'b0; bus.div_sel_req = DIV_1; bus.err_clr = 1'b0;
        fixed_delay = 3; never_pct = 0; slow_div = 24;
        sw_reset();
        model_reset();
        #12;
        check_reset("por");

        // Power-up switch to HS with a 3-cycle acknowledge.
        first_rise = 0; run_cyc = 0;
        for (int i = 1; i <= 40 && run_cyc == 0; i++) begin
            do_cycle(0);
            if (bus.hsclk_sel && first_rise == 0) first_rise = i;
            if (bus.running_hs) run_cyc = i;
        end
        check("first_rise_cycle", 32'(first_rise), 32'(4));
        check("hs_run_latency", 32'(run_cyc - first_rise), 32'(5));
        check("count_after_first", 32'(bus.switch_count), 32'(1));

        // Divider request is ignored while running fast.
        bus.div_sel_req = DIV_4;
        repeat (3) do_cycle(0);
        check("div_frozen_hs", 32'(bus.cpuclk_div_sel), 32'(DIV_1));

        bus.slow_req = 1'b1;
        do_cycle(0);
        check("slow_sel_drop", 32'(bus.hsclk_sel), 32'(0));
        check("slow_busy", 32'(bus.busy), 32'(1));
        n = 0;
        while (bus.busy && n < 40) begin do_cycle(0); n++; end
        check("to_ls_done", 32'(bus.busy), 32'(0));

        bus.slow_req = 1'b0;
        do_cycle(0);
        check("div_applied_ls", 32'(bus.cpuclk_div_sel), 32'(DIV_4));
        n = 1;
        while (!bus.hsclk_sel && n < 20) begin do_cycle(0); n++; end
        check("ls_dwell_edges", 32'(n), 32'(MIN_LS));

        // Abort one cycle into TO_HS.
        bus.slow_req = 1'b1;
        do_cycle(0);
        check("abort_sel", 32'(bus.hsclk_sel), 32'(0));
        check("abort_busy", 32'(bus.busy), 32'(1));
        n = 0;
        while (bus.busy && n < 40) begin do_cycle(0); n++; end
        check("abort_done", 32'(bus.busy), 32'(0));
        check("abort_count", 32'(bus.switch_count), 32'(1));
        bus.slow_req = 1'b0;

        // HS never acknowledged: timeout after TMO cycles in TO_HS.
        fixed_delay = 40;
        n = 0;
        while (!bus.hsclk_sel && n < 20) begin do_cycle(0); n++; end
        n = 0;
        while (bus.hsclk_sel && n < 40) begin do_cycle(0); n++; end
        check("tmo_cycles", 32'(n), 32'(TMO));
        check("tmo_err", 32'(bus.timeout_err), 32'(1));
        check("tmo_count", 32'(bus.switch_count), 32'(1));
        bus.err_clr = 1'b1;
        do_cycle(0);
        bus.err_clr = 1'b0;
        check("err_cleared", 32'(bus.timeout_err), 32'(0));

        // Asynchronous reset while switching and while running fast.
        fixed_delay = 3;
        n = 0;
        while (!(bus.busy && bus.hsclk_sel) && n < 40) begin do_cycle(0); n++; end
        check("reached_to_hs", 32'(bus.busy && bus.hsclk_sel), 32'(1));
        async_reset("arst_to_hs");
        n = 0;
        while (!bus.running_hs && n < 40) begin do_cycle(0); n++; end
        check("restart_run", 32'(bus.running_hs), 32'(1));
        async_reset("arst_hs_run");
        n = 0;
        while (!bus.running_hs && n < 40) begin do_cycle(0); n++; end
        check("restart_count", 32'(bus.switch_count), 32'(1));

        // Randomized phases: normal, busy slow_req traffic, frequent missing acknowledges.
        fixed_delay = 0;
        for (int ph = 0; ph < 3; ph++) begin
            slow_div  = (ph == 1) ? 4 : 24;
            never_pct = (ph == 2) ? 30 : 0;
            for (int i = 0; i < 1200; i++) begin
                do_cycle(1);
                if ($urandom_range(0, 249) == 0 && (bus.busy || bus.running_hs))
                    async_reset("arst_rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/clksw_sequencer.md
Name: clksw_sequencer

Overview:
Sequencer in the lsclk_in (host PHI2) domain that drives the hsclk_sel and cpuclk_div_sel inputs of the HS/LS clock switch. It decides when the CPU runs on the divided fast clock and when it falls back to the host clock. It applies the switch handshake using the switch's hsclk_selected/lsclk_selected status, enforces a minimum LS dwell and a switch timeout, and changes the divider only while the HS clock is gated off.

Parameters:
MIN_LS_CYCLES, 4, lsclk cycles to stay in LS_RUN before a switch to HS is allowed (1..255)
TIMEOUT_CYCLES, 16, lsclk cycles allowed in TO_HS/TO_LS before forced fallback (2..255)
DIV_RST, 2'b00, cpuclk_div_sel value at reset
CNT_W, 8, switch_count width

Ports:
lsclk_in  in  1  host/slow clock, all logic on posedge
rst_b  in  1  asynchronous, active-low reset
hs_en  in  1  global permission to run fast; 0 forces LS
slow_req  in  1  CPU access needs host bus (LS clock), level, lsclk domain
div_sel_req  in  2  requested HS divider (00 /1, 01 /2, 10 /4, 11 /8)
hsclk_selected  in  1  switch status, HS domain (async here)
lsclk_selected  in  1  switch status, lsclk domain
err_clr  in  1  clears timeout_err
hsclk_sel  out  1  to clock switch
cpuclk_div_sel  out  2  to clock switch
busy  out  1  1 in TO_HS/TO_LS
running_hs  out  1  1 in HS_RUN
timeout_err  out  1  sticky timeout flag
switch_count  out  CNT_W  completed LS->HS switches, wraps

Behaviour:
- All outputs are registered. Reset values: hsclk_sel=0, cpuclk_div_sel=DIV_RST, busy=0, running_hs=0, timeout_err=0, switch_count=0. FSM resets to LS_RUN with dwell counter 0.
- hs_sync is hsclk_selected passed through a 2-FF synchronizer. Latency is 2 lsclk edges. The synchronizer resets to 0.
- FSM states: LS_RUN, TO_HS, HS_RUN, TO_LS. Encoding is 2 bits.
- LS_RUN:
  - hsclk_sel=0.
  - Dwell counter increments and saturates at MIN_LS_CYCLES.
  - cpuclk_div_sel<=div_sel_req every cycle.
  - Exit to TO_HS when hs_en & !slow_req & dwell==MIN_LS_CYCLES & !hs_sync. hsclk_sel goes to 1 on the same edge.
- TO_HS:
  - div is frozen and the timer counts.
  - hs_sync=1 -> HS_RUN, switch_count+1 (wraps at 2^CNT_W).
  - slow_req or !hs_en -> TO_LS, hsclk_sel<=0, timer restarts (abort).
- HS_RUN:
  - div is frozen; div_sel_req changes are ignored until the next LS_RUN.
  - slow_req or !hs_en -> TO_LS, hsclk_sel<=0, timer restarts.
- TO_LS:
  - lsclk_selected & !hs_sync -> LS_RUN, dwell counter cleared to 0.
  - slow_req deassertion is ignored; completion of TO_LS is mandatory.
- Timeout:
  - The timer reaching TIMEOUT_CYCLES in TO_HS or TO_LS forces LS_RUN with hsclk_sel=0 and sets timeout_err.
  - Timeout has priority over every other transition in the same cycle.
  - After a TO_HS timeout, dwell is cleared, so a retry occurs after MIN_LS_CYCLES.
- timeout_err is sticky. err_clr clears it. A new timeout in the same cycle as err_clr wins, so the flag stays 1.
- busy=1 in TO_HS/TO_LS. running_hs=1 only in HS_RUN. Both are decoded from the next state, so they are aligned with hsclk_sel.
- Asynchronous reset mid-switch returns immediately to the reset values. The clock switch shares rst_b, so both sides restart consistently in LS.
- Invariant: cpuclk_div_sel changes only while the FSM is in LS_RUN and hs_sync==0.

Decomposition:
- Shared package clksw_pkg: FSM state typedef (LS_RUN=0, TO_HS=1, HS_RUN=2, TO_LS=3), divider encoding constants DIV_1/2/4/8.
- One sub-module: sync2_ff. It is a 2-FF synchronizer with async active-low reset and reset value as a parameter, reused for hs_sync.
- Dwell counter, timeout timer and switch_count stay inline.

Test Plan:
- Reset release with hs_en=1, slow_req=0, switch model acking HS after 3 cycles -> hsclk_sel rises 4 cycles after reset; running_hs is 1 about 5 cycles later (3-cycle ack + 2-cycle sync); switch_count=1.
- In HS_RUN, raise slow_req; model asserts lsclk_selected 2 cycles later -> hsclk_sel=0 next edge, busy=1 for about 2 cycles, then LS_RUN. Drop slow_req; hsclk_sel stays 0 for exactly 4 cycles, then rises again.
- Change div_sel_req 00->10 during HS_RUN -> cpuclk_div_sel stays 00. After the next entry to LS_RUN it becomes 10 within 1 cycle and never changes while hsclk_sel=1.
- Model never acks HS -> after 16 cycles in TO_HS: hsclk_sel=0, timeout_err=1, state LS_RUN, switch_count unchanged. err_clr pulse -> timeout_err=0.
- slow_req asserted 1 cycle after entering TO_HS -> abort to TO_LS with hsclk_sel=0. Then LS_RUN on ack; switch_count unchanged.
- rst_b pulsed low in TO_HS and in HS_RUN -> all outputs return to reset values asynchronously with no glitch on hsclk_sel; the normal sequence restarts.
